// File: rtl/t_toggle_monitor_if.sv
// Handshake and measurement bundle for t_toggle_monitor.
//   start        - measurement request (sampled only while idle)
//   q_in         - T flip-flop q output under observation
//   ready        - consumer accepts the result while valid is high
//   busy         - monitor is measuring or holding a result
//   valid        - result fields hold a completed measurement
//   toggle_count - q_in edges seen in the window
//   high_cycles  - window cycles with q_in high
//   overflow     - a counter saturated during the window
// master: the side that requests measurements and consumes results.
// slave:  the monitor itself.
interface t_toggle_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             q_in;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] toggle_count;
  logic [CNT_W-1:0] high_cycles;
  logic             overflow;

  modport master (
    output start, q_in, ready,
    input  busy, valid, toggle_count, high_cycles, overflow
  );

  modport slave (
    input  start, q_in, ready,
    output busy, valid, toggle_count, high_cycles, overflow
  );
endinterface

// File: rtl/t_toggle_monitor.sv
// Measures activity of a T flip-flop output over a fixed window.
// On start it samples q_in for WINDOW cycles, counting edges of q_in and cycles where
// q_in is high, then presents the result on a valid/ready handshake.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   mon   - t_toggle_monitor_if slave modport (start/q_in/ready in, results out)
// Parameters:
//   WINDOW - cycles sampled per measurement (2..65536)
//   CNT_W  - result counter width; counters saturate at all-ones and set overflow.
//            Must match the CNT_W of the connected interface.
module t_toggle_monitor #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input logic               clk,
  input logic               reset,
  t_toggle_monitor_if.slave mon
);

  localparam int unsigned WinW = $clog2(WINDOW + 1);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StMeasure, StReport} state_e;

  state_e            state_q, state_d;
  logic              q_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [CNT_W-1:0]  tog_q, tog_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              ovf_q, ovf_d;
  logic              q_edge;

  // q_d tracks q_in in every state so the first window sample has a valid reference.
  assign q_edge = (mon.q_in != q_d);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    tog_d   = tog_q;
    high_d  = high_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (mon.start) begin
          state_d = StMeasure;
          win_d   = '0;
          tog_d   = '0;
          high_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      StMeasure: begin
        if (q_edge) begin
          if (tog_q == CntMax) ovf_d = 1'b1;
          else                 tog_d = tog_q + CNT_W'(1);
        end
        if (mon.q_in) begin
          if (high_q == CntMax) ovf_d  = 1'b1;
          else                  high_d = high_q + CNT_W'(1);
        end
        win_d = win_q + WinW'(1);
        // The sample that brings win_cnt to WINDOW is the last one of the window.
        if (win_q == WinLast) state_d = StReport;
      end
      StReport: begin
        if (mon.ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      q_d     <= 1'b0;
      win_q   <= '0;
      tog_q   <= '0;
      high_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_d     <= mon.q_in;
      win_q   <= win_d;
      tog_q   <= tog_d;
      high_q  <= high_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mon.busy         = (state_q != StIdle);
  assign mon.valid        = (state_q == StReport);
  assign mon.toggle_count = tog_q;
  assign mon.high_cycles  = high_q;
  assign mon.overflow     = ovf_q;

endmodule

// File: doc/t_toggle_monitor.md
Name: t_toggle_monitor

Overview:
- Downstream consumer of the T flip-flop output q, in the same clock domain.
- On a start request it measures q over a fixed window of clock cycles and counts two things: edges (toggles) of q, and cycles in which q is high.
- Results are presented on a valid/ready handshake.
- Used to check T-FF toggle activity and duty cycle in system-level benches and in self-test logic.

Parameters:
- WINDOW, 16, number of clock cycles sampled per measurement (legal range 2..65536).
- CNT_W, 8, width of both result counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  measurement request; sampled only in IDLE.
- q_in  input  1  T flip-flop q output, synchronous to clk.
- ready  input  1  consumer accepts the result when high while valid is high.
- busy  output  1  high in MEASURE and REPORT.
- valid  output  1  result registers hold a completed measurement.
- toggle_count  output  CNT_W  number of q_in edges seen in the window.
- high_cycles  output  CNT_W  number of window cycles with q_in=1.
- overflow  output  1  a counter saturated during this window.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; q_d=0; window counter=0.
  - busy, valid, toggle_count, high_cycles and overflow are all 0.
  - A reset mid-MEASURE or mid-REPORT discards the result; no valid is produced.
- Edge detector:
  - q_d <= q_in on every posedge in every state, including IDLE.
  - edge = (q_in != q_d), evaluated at the sampling posedge.
  - The first MEASURE sample compares against the value q_d captured in the preceding cycle.
- States: IDLE, MEASURE, REPORT.
- IDLE:
  - start=1 at posedge k: state becomes MEASURE, counters clear to 0, overflow clears, win_cnt clears to 0, busy becomes 1.
  - Result outputs keep their last values but valid=0.
- MEASURE:
  - Posedges k+1 .. k+WINDOW each take one sample.
  - On each sample: toggle_count += edge; high_cycles += q_in; win_cnt += 1.
  - Saturation: an increment attempted while a counter is at 2^CNT_W-1 leaves the counter unchanged and sets overflow=1 (sticky until the next start).
  - At posedge k+WINDOW (sample number WINDOW, which is included in the counts): state becomes REPORT and valid becomes 1.
  - Result latency: valid is high in the cycle following posedge k+WINDOW.
  - start is ignored.
- REPORT:
  - valid=1; toggle_count, high_cycles and overflow are held stable.
  - On a posedge with ready=1: valid becomes 0, busy becomes 0, state becomes IDLE.
  - ready=0 holds everything indefinitely; there is no timeout.
  - start is ignored, including on the handshake cycle.
  - The earliest new start is sampled on the posedge after returning to IDLE.
- ready while valid=0 has no effect.
- win_cnt width is clog2(WINDOW+1) bits; counter arithmetic is unsigned with no wrap-around.

Test Plan:
- Reset mid-operation:
  - Stimulus: start, then reset=0 after 5 MEASURE cycles, then release reset.
  - Required response: all outputs 0 immediately (no clock needed); state IDLE; no valid without a new start.
- Static input:
  - Stimulus: q_in=0 constant, start pulse, ready=1.
  - Required response: valid rises 16 cycles after the start posedge; toggle_count=0, high_cycles=0, overflow=0; busy=0 one cycle after the handshake.
- T-FF toggling every cycle:
  - Stimulus: q_in from t_flip_flop with t=1, toggling well before start.
  - Required response: toggle_count=16, high_cycles=8, overflow=0.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles after valid, with start pulsed during REPORT; then ready=1.
  - Required response: outputs stable and valid held throughout; start ignored; after ready=1, valid=0 at the next posedge and state is IDLE.
- Saturation (CNT_W=3, WINDOW=16):
  - Stimulus: q_in toggling every cycle.
  - Required response: toggle_count=7, high_cycles=7, overflow=1; overflow=0 again after the next start.
- Back-to-back windows:
  - Stimulus: start held at 1, ready held at 1, q_in toggling every 2 cycles.
  - Required response: windows repeat with one IDLE cycle between them; every result reports toggle_count=8, high_cycles=8; exactly one valid cycle per window.
